// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS subset CPU.
//
// Every instruction is fetched, decoded, executed, given its memory access
// and written back within one rising edge of clk. Instruction and data
// memories are internal word arrays indexed by address bits [AW+1:2]. Upper
// address bits are ignored, so addresses wrap around the array.
//
// Parameters:
//   MEM_DEPTH   - number of 32-bit words in each of instruction and data RAM
// Ports:
//   clk         - single clock; all state updates on the rising edge
//   reset       - synchronous, active-high; clears PC and registers, not RAMs
//   regs_debug  - live copy of the register file, index n = $n
//   pc_debug    - address of the instruction executing this cycle
//   instr_debug - instruction word at the current PC

// Word RAM with a combinational read port and a write port on the clock edge.
// The instruction memory instance ties its write port off. It is loaded
// hierarchically through `mem`.
module cpu_ram #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:MEM_DEPTH-1];

    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end
endmodule

module single_cycle_cpu #(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] regs_debug [0:31],
    output logic [31:0] pc_debug,
    output logic [31:0] instr_debug
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    logic [31:0] pc;
    logic [31:0] regs [0:31];
    logic [31:0] instr;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;

    logic        reg_write, reg_dst_rd, alu_src_imm, imm_zext;
    logic        mem_write, mem_to_reg, branch_eq, branch_ne, jump;
    alu_op_e     alu_op;

    logic [31:0] rs_val, rt_val, ext_imm, alu_b, alu_result;
    logic [31:0] dmem_rdata, wb_data;
    logic [4:0]  wb_addr;
    logic [31:0] pc_plus4, branch_target, jump_target, next_pc;
    logic        branch_taken;

    cpu_ram #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) instr_ram (
        .clk   (clk),
        .we    (1'b0),
        .idx   (pc[AW+1:2]),
        .wdata ('0),
        .rdata (instr)
    );

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    // Main and ALU control. Anything not decoded leaves every enable low,
    // so the instruction behaves as a NOP.
    always_comb begin
        reg_write   = 1'b0;
        reg_dst_rd  = 1'b0;
        alu_src_imm = 1'b0;
        imm_zext    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        branch_eq   = 1'b0;
        branch_ne   = 1'b0;
        jump        = 1'b0;
        alu_op      = ALU_ADD;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20: begin reg_write = 1'b1; reg_dst_rd = 1'b1; alu_op = ALU_ADD; end
                    6'h22: begin reg_write = 1'b1; reg_dst_rd = 1'b1; alu_op = ALU_SUB; end
                    6'h24: begin reg_write = 1'b1; reg_dst_rd = 1'b1; alu_op = ALU_AND; end
                    6'h25: begin reg_write = 1'b1; reg_dst_rd = 1'b1; alu_op = ALU_OR;  end
                    6'h2A: begin reg_write = 1'b1; reg_dst_rd = 1'b1; alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            6'h08: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_ADD; end
            6'h0C: begin reg_write = 1'b1; alu_src_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
            6'h0D: begin reg_write = 1'b1; alu_src_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR; end
            6'h0A: begin reg_write = 1'b1; alu_src_imm = 1'b1; alu_op = ALU_SLT; end
            6'h23: begin reg_write = 1'b1; alu_src_imm = 1'b1; mem_to_reg = 1'b1; end
            6'h2B: begin mem_write = 1'b1; alu_src_imm = 1'b1; end
            6'h04: begin branch_eq = 1'b1; end
            6'h05: begin branch_ne = 1'b1; end
            6'h02: begin jump = 1'b1; end
            default: ;
        endcase
    end

    assign rs_val  = regs[rs];
    assign rt_val  = regs[rt];
    assign ext_imm = imm_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = alu_src_imm ? ext_imm : rt_val;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = rs_val + alu_b;
            ALU_SUB: alu_result = rs_val - alu_b;
            ALU_AND: alu_result = rs_val & alu_b;
            ALU_OR:  alu_result = rs_val | alu_b;
            ALU_SLT: alu_result = {31'b0, $signed(rs_val) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end

    // Gating with reset drops a store that coincides with a reset edge.
    cpu_ram #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) data_ram (
        .clk   (clk),
        .we    (mem_write & ~reset),
        .idx   (alu_result[AW+1:2]),
        .wdata (rt_val),
        .rdata (dmem_rdata)
    );

    assign wb_data = mem_to_reg ? dmem_rdata : alu_result;
    assign wb_addr = reg_dst_rd ? rd : rt;

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {ext_imm[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_taken  = (branch_eq & (rs_val == rt_val)) |
                           (branch_ne & (rs_val != rt_val));
    assign next_pc       = jump ? jump_target : (branch_taken ? branch_target : pc_plus4);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc <= next_pc;
            if (reg_write && wb_addr != 5'd0) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

    assign regs_debug  = regs;
    assign pc_debug    = pc;
    assign instr_debug = instr;
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Self-checking bench for single_cycle_cpu. Programs are written straight
// into dut.instr_ram.mem. Expected register values come from a table. They
// are queued when a program is launched and compared after it has run.
// Hand-written sequences cover reset, the undefined opcode, jumps and
// aborting a store with reset.
module tb_single_cycle_cpu;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] regs_debug [0:31];
    logic [31:0] pc_debug;
    logic [31:0] instr_debug;

    int total = 0;
    int bad   = 0;

    single_cycle_cpu #(.MEM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .regs_debug  (regs_debug),
        .pc_debug    (pc_debug),
        .instr_debug (instr_debug)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          prog;
        string       name;
        int unsigned r;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [$];
    vec_t        sb   [$];
    logic [31:0] prog_words [0:31];

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rt3(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] jt(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic build(input int p);
        for (int i = 0; i < 32; i++) prog_words[i] = 32'h0;
        case (p)
            1: begin
                prog_words[0] = it(6'h08, 5'd0, 5'd8, 16'd8);
                prog_words[1] = it(6'h08, 5'd0, 5'd9, 16'd7);
                prog_words[2] = rt3(5'd8, 5'd9, 5'd10, 6'h20);
                prog_words[3] = rt3(5'd9, 5'd8, 5'd11, 6'h2A);
            end
            2: begin
                prog_words[0]  = it(6'h08, 5'd0, 5'd0, 16'd5);
                prog_words[1]  = it(6'h08, 5'd0, 5'd8, 16'hFFFF);
                prog_words[2]  = it(6'h0D, 5'd0, 5'd9, 16'hFFFF);
                prog_words[3]  = it(6'h08, 5'd0, 5'd10, 16'h1234);
                prog_words[4]  = it(6'h2B, 5'd0, 5'd10, 16'd8);
                prog_words[5]  = it(6'h23, 5'd0, 5'd11, 16'd8);
                prog_words[6]  = it(6'h08, 5'd0, 5'd12, 16'hFFFB);
                prog_words[7]  = it(6'h08, 5'd0, 5'd13, 16'd3);
                prog_words[8]  = rt3(5'd12, 5'd13, 5'd14, 6'h2A);
                prog_words[9]  = it(6'h3F, 5'd0, 5'd20, 16'd1);
                prog_words[10] = rt3(5'd13, 5'd12, 5'd15, 6'h22);
                prog_words[11] = rt3(5'd8, 5'd9, 5'd16, 6'h24);
                prog_words[12] = it(6'h0A, 5'd12, 5'd17, 16'd0);
                prog_words[13] = it(6'h0C, 5'd8, 5'd18, 16'h00F0);
                prog_words[14] = rt3(5'd9, 5'd10, 5'd19, 6'h25);
                prog_words[15] = rt3(5'd8, 5'd8, 5'd21, 6'h20);
            end
            3: begin
                prog_words[0]  = it(6'h08, 5'd0, 5'd8, 16'd1);
                prog_words[1]  = it(6'h08, 5'd0, 5'd9, 16'd1);
                prog_words[2]  = it(6'h04, 5'd8, 5'd9, 16'd1);
                prog_words[3]  = it(6'h08, 5'd0, 5'd10, 16'd7);
                prog_words[4]  = it(6'h08, 5'd0, 5'd11, 16'd2);
                prog_words[5]  = it(6'h04, 5'd8, 5'd0, 16'd1);
                prog_words[6]  = it(6'h08, 5'd0, 5'd12, 16'd3);
                prog_words[7]  = it(6'h05, 5'd8, 5'd0, 16'd1);
                prog_words[8]  = it(6'h08, 5'd0, 5'd13, 16'd9);
                prog_words[9]  = jt(26'h10);
                prog_words[10] = it(6'h08, 5'd0, 5'd14, 16'd5);
                prog_words[16] = it(6'h08, 5'd0, 5'd15, 16'd6);
                prog_words[17] = jt(26'h11);
            end
            default: begin
                prog_words[0] = it(6'h23, 5'd0, 5'd9, 16'd16);
                prog_words[1] = it(6'h08, 5'd0, 5'd8, 16'h0055);
                prog_words[2] = it(6'h2B, 5'd0, 5'd8, 16'd16);
                prog_words[3] = jt(26'h3);
            end
        endcase
    endtask

    // Holds reset while loading, then releases it after two reset edges.
    task automatic load_and_reset(input int p);
        reset = 1'b1;
        build(p);
        for (int i = 0; i < int'(DEPTH); i++)
            dut.instr_ram.mem[i] = (i < 32) ? prog_words[i] : 32'h0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic queue_expect(input int p);
        foreach (vecs[k]) if (vecs[k].prog == p) sb.push_back(vecs[k]);
    endtask

    task automatic drain;
        vec_t v;
        while (sb.size() > 0) begin
            v = sb.pop_front();
            chk(v.name, regs_debug[v.r], v.exp);
        end
    endtask

    initial begin
        vecs = '{
            '{1, "p1_t0",      8,  32'h0000_0008},
            '{1, "p1_t1",      9,  32'h0000_0007},
            '{1, "p1_add",     10, 32'h0000_000F},
            '{1, "p1_slt",     11, 32'h0000_0001},
            '{2, "zero_reg",   0,  32'h0000_0000},
            '{2, "addi_neg1",  8,  32'hFFFF_FFFF},
            '{2, "ori_zext",   9,  32'h0000_FFFF},
            '{2, "addi_1234",  10, 32'h0000_1234},
            '{2, "lw_roundtr", 11, 32'h0000_1234},
            '{2, "slt_neg",    14, 32'h0000_0001},
            '{2, "sub",        15, 32'h0000_0008},
            '{2, "and",        16, 32'h0000_FFFF},
            '{2, "slti",       17, 32'h0000_0001},
            '{2, "andi",       18, 32'h0000_00F0},
            '{2, "or",         19, 32'h0000_FFFF},
            '{2, "undef_nowr", 20, 32'h0000_0000},
            '{2, "add_wrap",   21, 32'hFFFF_FFFE},
            '{3, "beq_skip",   10, 32'h0000_0000},
            '{3, "beq_after",  11, 32'h0000_0002},
            '{3, "beq_nt",     12, 32'h0000_0003},
            '{3, "bne_skip",   13, 32'h0000_0000},
            '{3, "j_skip",     14, 32'h0000_0000},
            '{3, "j_target",   15, 32'h0000_0006}
        };

        // Basic program, then reset with live state.
        load_and_reset(1);
        chk("p1_reset_pc", pc_debug, 32'h0);
        queue_expect(1);
        step(20);
        chk("p1_pc", pc_debug, 32'h50);
        drain();
        reset = 1'b1;
        step(1);
        chk("rst_pc", pc_debug, 32'h0);
        chk("rst_instr", instr_debug, prog_words[0]);
        for (int r = 0; r < 32; r++) chk($sformatf("rst_reg%0d", r), regs_debug[r], 32'h0);
        reset = 1'b0;

        // Arithmetic edges, memory round trip, undefined opcode.
        load_and_reset(2);
        queue_expect(2);
        step(9);
        chk("undef_pc", pc_debug, 32'h24);
        chk("undef_instr", instr_debug, prog_words[9]);
        step(1);
        chk("undef_pc4", pc_debug, 32'h28);
        step(6);
        drain();

        // Branches and jump.
        load_and_reset(3);
        queue_expect(3);
        step(2);
        chk("beq_pc", pc_debug, 32'h08);
        step(1);
        chk("beq_taken_pc", pc_debug, 32'h10);
        step(4);
        chk("bne_taken_pc", pc_debug, 32'h24);
        step(1);
        chk("j_pc", pc_debug, 32'h40);
        step(4);
        chk("j_loop_pc", pc_debug, 32'h44);
        drain();

        // Reset during a store suppresses the store.
        dut.data_ram.mem[4] = 32'h0;
        load_and_reset(4);
        step(2);
        chk("abort_pc", pc_debug, 32'h08);
        chk("abort_t0", regs_debug[8], 32'h55);
        reset = 1'b1;
        step(1);
        chk("abort_rst_pc", pc_debug, 32'h0);
        chk("abort_rst_t0", regs_debug[8], 32'h0);
        reset = 1'b0;
        step(1);
        chk("sw_suppressed", regs_debug[9], 32'h0);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        chk("sw_done", regs_debug[9], 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
